umi_regarray: RTL and testbench



---
 rtl/umi_regarray.sv | 188 ++++++++++++++++++
 tb/tb_umi_regarray.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_regarray.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | umi_regarray: UMI register-array endpoint (bursts, RO mask, error resp).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module umi_regarray #(
  parameter int                  RW        = 32,
  parameter int                  RAW       = 5,
  parameter int                  DW        = 64,
  parameter int                  CW        = 32,
  parameter int                  AW        = 64,
  parameter int                  GRPOFFSET = 24,
  parameter int                  GRPAW     = 0,
  parameter int                  GRPID     = 0,
  parameter logic [2**RAW-1:0]   ROMASK    = '0,
  parameter int                  SAFE      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   udev_req_valid,
  input  logic [CW-1:0]          udev_req_cmd,
  input  logic [AW-1:0]          udev_req_dstaddr,
  input  logic [AW-1:0]          udev_req_srcaddr,
  input  logic [DW-1:0]          udev_req_data,
  output logic                   udev_req_ready,
  output logic                   udev_resp_valid,
  output logic [CW-1:0]          udev_resp_cmd,
  output logic [AW-1:0]          udev_resp_dstaddr,
  output logic [AW-1:0]          udev_resp_srcaddr,
  output logic [DW-1:0]          udev_resp_data,
  input  logic                   udev_resp_ready,
  output logic [2**RAW*RW-1:0]   regs_out
);

  localparam int         c_NREG       = 2**RAW;
  localparam int         c_NW         = DW / RW;
  localparam int         c_ALIGN      = $clog2(RW / 8);
  localparam logic [4:0] c_REQ_READ   = 5'h01;
  localparam logic [4:0] c_REQ_WRITE  = 5'h03;
  localparam logic [4:0] c_REQ_POSTED = 5'h05;
  localparam logic [4:0] c_RESP_READ  = 5'h02;
  localparam logic [4:0] c_RESP_WRITE = 5'h04;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_regs [c_NREG];
  logic [CW-1:0]   r_resp_cmd;
  logic [AW-1:0]   r_resp_dst;
  logic [AW-1:0]   r_resp_src;
  logic [DW-1:0]   r_resp_data;

  logic [4:0]      w_opcode;
  logic [2:0]      w_size;
  logic [7:0]      w_len;
  logic [RAW-1:0]  w_base;
  logic            w_grp_ok;
  logic            w_op_read;
  logic            w_op_write;
  logic            w_op_posted;
  logic            w_fmt_ok;
  logic [1:0]      w_err;
  logic            w_legal;
  logic            w_beat;
  logic            w_need_resp;
  logic            w_do_write;
  logic [DW-1:0]   w_rdata;
  logic [CW-1:0]   w_resp_cmd;
  logic            w_unused;

  assign w_opcode    = udev_req_cmd[4:0];
  assign w_size      = udev_req_cmd[7:5];
  assign w_len       = udev_req_cmd[15:8];
  assign w_base      = udev_req_dstaddr[c_ALIGN +: RAW];
  assign w_unused    = ^{udev_req_dstaddr, udev_req_cmd};

  assign w_op_read   = (w_opcode == c_REQ_READ);
  assign w_op_write  = (w_opcode == c_REQ_WRITE);
  assign w_op_posted = (w_opcode == c_REQ_POSTED);
  assign w_fmt_ok    = (w_op_read | w_op_write | w_op_posted) &&
                       (w_size == 3'(c_ALIGN)) && (int'(w_len) < c_NW);

  generate
    if (GRPAW == 0) begin : g_nogrp
      assign w_grp_ok = 1'b1;
    end else begin : g_grp
      assign w_grp_ok = (udev_req_dstaddr[GRPOFFSET +: GRPAW] == GRPAW'(GRPID));
    end
  endgenerate

  // Group mismatch outranks any other decode error.
  assign w_err       = !w_grp_ok ? 2'b11 : (!w_fmt_ok ? 2'b10 : 2'b00);
  assign w_legal     = (w_err == 2'b00);
  assign w_beat      = udev_req_valid & udev_req_ready;
  assign w_need_resp = w_beat & ~w_op_posted;
  assign w_do_write  = w_beat & w_legal & (w_op_write | w_op_posted);

  always_comb begin
    w_rdata = '0;
    if (w_op_read && w_legal) begin
      for (int k = 0; k < c_NW; k++) begin
        if (k <= int'(w_len)) begin
          w_rdata[k*RW +: RW] = r_regs[w_base + RAW'(k)];
        end
      end
    end
  end

  always_comb begin
    w_resp_cmd        = udev_req_cmd;
    w_resp_cmd[4:0]   = w_op_read ? c_RESP_READ : c_RESP_WRITE;
    w_resp_cmd[26:25] = w_err;
  end

  // Indices wrap modulo NREG through the RAW-bit add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_do_write) begin
      for (int k = 0; k < c_NW; k++) begin
        if ((k <= int'(w_len)) && !ROMASK[w_base + RAW'(k)]) begin
          r_regs[w_base + RAW'(k)] <= udev_req_data[k*RW +: RW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_need_resp) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_need_resp)          w_state_nxt = S_RESP;
        else if (udev_resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_cmd  <= '0;
      r_resp_dst  <= '0;
      r_resp_src  <= '0;
      r_resp_data <= '0;
    end else if (w_need_resp) begin
      r_resp_cmd  <= w_resp_cmd;
      r_resp_dst  <= udev_req_srcaddr;
      r_resp_src  <= udev_req_dstaddr;
      r_resp_data <= w_rdata;
    end
  end

  assign udev_resp_valid   = (r_state == S_RESP);
  assign udev_resp_cmd     = r_resp_cmd;
  assign udev_resp_dstaddr = r_resp_dst;
  assign udev_resp_srcaddr = r_resp_src;
  assign udev_resp_data    = r_resp_data;

  generate
    if (SAFE != 0) begin : g_safe
      assign udev_req_ready = ~udev_resp_valid;
    end else begin : g_fast
      assign udev_req_ready = ~udev_resp_valid | udev_resp_ready;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < c_NREG; gi++) begin : g_mirror
      assign regs_out[gi*RW +: RW] = r_regs[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_umi_regarray.sv
`default_nettype none
// tb_umi_regarray: two configurations (default SAFE=1; grouped, RO reg4, SAFE=0)
// driven with shared stimulus and compared every cycle against a behavioural model.
module tb_umi_regarray;

  localparam int         NI    = 2;
  localparam logic [4:0] OP_RD = 5'h01;
  localparam logic [4:0] OP_WR = 5'h03;
  localparam logic [4:0] OP_PO = 5'h05;
  localparam logic [4:0] OP_AT = 5'h09;
  localparam logic [4:0] RS_RD = 5'h02;
  localparam logic [4:0] RS_WR = 5'h04;
  localparam logic [63:0] SRC  = 64'h0000_00AB_CDEF_0123;
  localparam logic [63:0] G    = 64'h0000_0000_5A00_0000;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          resp_ready;
  logic [31:0]   req_cmd;
  logic [63:0]   req_dst;
  logic [63:0]   req_src;
  logic [63:0]   req_data;
  logic          req_ready  [NI];
  logic          resp_valid [NI];
  logic [31:0]   resp_cmd   [NI];
  logic [63:0]   resp_dst   [NI];
  logic [63:0]   resp_src   [NI];
  logic [63:0]   resp_data  [NI];
  logic [1023:0] regs_out   [NI];

  umi_regarray dut_a (
    .clk(clk), .reset(reset),
    .udev_req_valid(req_valid), .udev_req_cmd(req_cmd), .udev_req_dstaddr(req_dst),
    .udev_req_srcaddr(req_src), .udev_req_data(req_data), .udev_req_ready(req_ready[0]),
    .udev_resp_valid(resp_valid[0]), .udev_resp_cmd(resp_cmd[0]),
    .udev_resp_dstaddr(resp_dst[0]), .udev_resp_srcaddr(resp_src[0]),
    .udev_resp_data(resp_data[0]), .udev_resp_ready(resp_ready), .regs_out(regs_out[0])
  );

  umi_regarray #(.GRPAW(8), .GRPID(32'h5A), .ROMASK(32'h0000_0010), .SAFE(0)) dut_b (
    .clk(clk), .reset(reset),
    .udev_req_valid(req_valid), .udev_req_cmd(req_cmd), .udev_req_dstaddr(req_dst),
    .udev_req_srcaddr(req_src), .udev_req_data(req_data), .udev_req_ready(req_ready[1]),
    .udev_resp_valid(resp_valid[1]), .udev_resp_cmd(resp_cmd[1]),
    .udev_resp_dstaddr(resp_dst[1]), .udev_resp_srcaddr(resp_src[1]),
    .udev_resp_data(resp_data[1]), .udev_resp_ready(resp_ready), .regs_out(regs_out[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state: register file plus the one outstanding response.
  logic [31:0] m_regs [NI][32];
  bit          m_rv   [NI];
  logic [31:0] m_cmd  [NI];
  logic [63:0] m_dst  [NI];
  logic [63:0] m_src  [NI];
  logic [63:0] m_data [NI];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;

  function automatic bit exp_ready(input int i);
    return (i == 0) ? !m_rv[i] : (!m_rv[i] || resp_ready);
  endfunction

  function automatic logic [31:0] reg_of(input int i, input int r);
    return regs_out[i][r*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_rv[i] = 1'b0; m_cmd[i] = '0; m_dst[i] = '0; m_src[i] = '0; m_data[i] = '0;
      for (int r = 0; r < 32; r++) m_regs[i][r] = '0;
    end
  endtask

  task automatic model_beat(input int i);
    logic [4:0]  op;
    int          len;
    int          base;
    bit          grp_bad;
    bit          fmt_bad;
    logic [1:0]  err;
    logic [63:0] rd;
    op      = req_cmd[4:0];
    len     = int'(req_cmd[15:8]);
    base    = int'(req_dst[6:2]);
    grp_bad = (i == 1) && (req_dst[31:24] != 8'h5A);
    fmt_bad = !(op == OP_RD || op == OP_WR || op == OP_PO) || (req_cmd[7:5] != 3'd2) || (len > 1);
    err     = grp_bad ? 2'b11 : (fmt_bad ? 2'b10 : 2'b00);
    rd      = '0;
    if (err == 2'b00 && op == OP_RD)
      for (int k = 0; k <= len; k++) rd[k*32 +: 32] = m_regs[i][(base + k) % 32];
    if (err == 2'b00 && (op == OP_WR || op == OP_PO))
      for (int k = 0; k <= len; k++)
        if (!(i == 1 && ((base + k) % 32) == 4)) m_regs[i][(base + k) % 32] = req_data[k*32 +: 32];
    if (op != OP_PO) begin
      m_rv[i]   = 1'b1;
      m_cmd[i]  = {req_cmd[31:27], err, req_cmd[24:5], (op == OP_RD) ? RS_RD : RS_WR};
      m_dst[i]  = req_src;
      m_src[i]  = req_dst;
      m_data[i] = rd;
    end
  endtask

  initial begin
    bit rdy;
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        for (int i = 0; i < NI; i++) begin
          rdy = exp_ready(i);
          if (m_rv[i] && resp_ready) m_rv[i] = 1'b0;
          if (req_valid && rdy) model_beat(i);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input int i);
    int bad;
    bad = -1;
    n_checks++;
    for (int r = 0; r < 32; r++) if (bad < 0 && reg_of(i, r) !== m_regs[i][r]) bad = r;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL regs_out[%0d] reg%0d: got %h expected %h at %0t", i, bad, reg_of(i, bad), m_regs[i][bad], $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(exp_ready(i)));
          chk($sformatf("resp_valid[%0d]", i), 64'(resp_valid[i]), 64'(m_rv[i]));
          if (m_rv[i]) begin
            chk($sformatf("resp_cmd[%0d]", i), 64'(resp_cmd[i]), 64'(m_cmd[i]));
            chk($sformatf("resp_dst[%0d]", i), resp_dst[i], m_dst[i]);
            chk($sformatf("resp_src[%0d]", i), resp_src[i], m_src[i]);
            chk($sformatf("resp_data[%0d]", i), resp_data[i], m_data[i]);
          end
          chk_regs(i);
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [2:0] size, input logic [7:0] len,
                      input logic [63:0] dst, input logic [63:0] data);
    @(negedge clk);
    req_valid  = 1'b1;
    req_cmd    = {16'hA5C3, len, size, op};
    req_dst    = dst;
    req_data   = data;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    #2;
  endtask

  initial begin
    int          cnt [NI];
    logic [31:0] rnd;
    int          sel;
    req_valid = 1'b0; resp_ready = 1'b1; req_cmd = '0; req_dst = '0; req_src = SRC; req_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", 64'(resp_valid[i]), 64'd0);
      chk("rst_regs", {63'd0, |regs_out[i]}, 64'd0);
      chk("rst_cmd", 64'(resp_cmd[i]), 64'd0);
      chk("rst_data", resp_data[i], 64'd0);
    end
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    send(OP_WR, 3'd2, 8'd1, G | 64'h08, 64'h22222222_11111111);
    for (int i = 0; i < NI; i++) begin
      chk("wr_valid", 64'(resp_valid[i]), 64'd1);
      chk("wr_op", 64'(resp_cmd[i][4:0]), 64'(RS_WR));
      chk("wr_err", 64'(resp_cmd[i][26:25]), 64'd0);
      chk("wr_dst", resp_dst[i], SRC);
      chk("wr_src", resp_src[i], G | 64'h08);
      chk("wr_reg2", 64'(reg_of(i, 2)), 64'h11111111);
      chk("wr_reg3", 64'(reg_of(i, 3)), 64'h22222222);
    end
    send(OP_RD, 3'd2, 8'd1, G | 64'h08, 64'd0);
    for (int i = 0; i < NI; i++) begin
      chk("rd1_data", resp_data[i], 64'h22222222_11111111);
      chk("rd1_op", 64'(resp_cmd[i][4:0]), 64'(RS_RD));
    end
    send(OP_RD, 3'd2, 8'd0, G | 64'h08, 64'd0);
    for (int i = 0; i < NI; i++) chk("rd0_data", resp_data[i], 64'h00000000_11111111);
    send(OP_WR, 3'd2, 8'd1, G | 64'h7C, 64'hBBBBBBBB_AAAAAAAA);
    for (int i = 0; i < NI; i++) begin
      chk("wrap_reg31", 64'(reg_of(i, 31)), 64'hAAAAAAAA);
      chk("wrap_reg0", 64'(regs_out[i][31:0]), 64'hBBBBBBBB);
    end
    send(OP_AT, 3'd2, 8'd0, G | 64'h08, 64'hDEAD);
    for (int i = 0; i < NI; i++) begin
      chk("atom_err", 64'(resp_cmd[i][26:25]), 64'd2);
      chk("atom_data", resp_data[i], 64'd0);
      chk("atom_reg2", 64'(reg_of(i, 2)), 64'h11111111);
    end
    send(OP_WR, 3'd2, 8'd2, G | 64'h08, 64'h33333333_33333333);
    for (int i = 0; i < NI; i++) begin
      chk("len2_err", 64'(resp_cmd[i][26:25]), 64'd2);
      chk("len2_reg2", 64'(reg_of(i, 2)), 64'h11111111);
    end
    send(OP_WR, 3'd3, 8'd0, G | 64'h08, 64'h44444444_44444444);
    for (int i = 0; i < NI; i++) begin
      chk("size3_err", 64'(resp_cmd[i][26:25]), 64'd2);
      chk("size3_reg2", 64'(reg_of(i, 2)), 64'h11111111);
    end
    send(OP_PO, 3'd2, 8'd2, G | 64'h08, 64'h66666666_66666666);
    for (int i = 0; i < NI; i++) begin
      chk("pbad_valid", 64'(resp_valid[i]), 64'd0);
      chk("pbad_reg2", 64'(reg_of(i, 2)), 64'h11111111);
    end
    send(OP_PO, 3'd2, 8'd0, G | 64'h14, 64'h55);
    for (int i = 0; i < NI; i++) begin
      chk("post_valid", 64'(resp_valid[i]), 64'd0);
      chk("post_reg5", 64'(reg_of(i, 5)), 64'h55);
    end
    send(OP_RD, 3'd2, 8'd0, 64'h5B00_0008, 64'd0);
    chk("grp_err_a", 64'(resp_cmd[0][26:25]), 64'd0);
    chk("grp_data_a", resp_data[0], 64'h11111111);
    chk("grp_err_b", 64'(resp_cmd[1][26:25]), 64'd3);
    chk("grp_data_b", resp_data[1], 64'd0);
    chk("grp_op_b", 64'(resp_cmd[1][4:0]), 64'(RS_RD));
    send(OP_WR, 3'd2, 8'd0, G | 64'h10, 64'hFFFFFFFF);
    chk("ro_reg4_a", 64'(reg_of(0, 4)), 64'hFFFFFFFF);
    chk("ro_reg4_b", 64'(reg_of(1, 4)), 64'd0);
    chk("ro_err_b", 64'(resp_cmd[1][26:25]), 64'd0);

    // Backpressure: response must hold for 5 cycles while a new request waits.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = {16'hA5C3, 8'd1, 3'd2, OP_RD}; req_dst = G | 64'h08; resp_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #2;
      for (int i = 0; i < NI; i++) begin
        chk("hold_valid", 64'(resp_valid[i]), 64'd1);
        chk("hold_ready", 64'(req_ready[i]), 64'd0);
        chk("hold_data", resp_data[i], 64'h22222222_11111111);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    cnt[0] = 0; cnt[1] = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_cmd = {16'h0000, 8'd0, 3'd2, OP_RD}; req_dst = G | 64'(8 + 4 * c);
      #2;
      for (int i = 0; i < NI; i++) if (req_ready[i]) cnt[i]++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_beats_a", 64'(cnt[0]), 64'd2);
    chk("b2b_beats_b", 64'(cnt[1]), 64'd4);
    repeat (2) @(negedge clk);

    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_cmd = {16'h0000, 8'd0, 3'd2, OP_RD}; req_dst = G | 64'h08;
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    for (int i = 0; i < NI; i++) chk("prerst_valid", 64'(resp_valid[i]), 64'd1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_valid", 64'(resp_valid[i]), 64'd0);
      chk("midrst_regs", {63'd0, |regs_out[i]}, 64'd0);
      chk("midrst_data", resp_data[i], 64'd0);
    end
    @(negedge clk);
    reset = 1'b0; resp_ready = 1'b1;

    repeat (1500) begin
      @(negedge clk);
      rnd       = $urandom();
      sel       = int'($urandom_range(0, 7));
      req_valid = ($urandom_range(0, 3) != 0);
      req_cmd   = {rnd[31:16],
                   ($urandom_range(0, 5) == 0) ? 8'd2 : 8'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
                   (sel < 3) ? OP_RD : (sel < 5) ? OP_WR : (sel == 5) ? OP_PO :
                   (sel == 6) ? OP_AT : 5'($urandom_range(0, 31))};
      req_dst   = {32'($urandom()), ($urandom_range(0, 4) == 0) ? 8'h5B : 8'h5A, 24'($urandom())};
      req_src   = {32'($urandom()), 32'($urandom())};
      req_data  = {32'($urandom()), 32'($urandom())};
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
